// File: rtl/arb_pkg.sv
// +--------------------------------------------------------------------------+
// | arb_pkg : shared widths, FSM encoding and helpers for rr_arbiter8       |
// | Rev 1.0 : initial release                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

package arb_pkg;

  localparam int NREQ   = 8;
  localparam int ID_W   = 3;
  localparam int HOLD_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NREQ-1:0] id2onehot(input logic [ID_W-1:0] id);
    logic [NREQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pick8.sv
// +--------------------------------------------------------------------------+
// | rr_pick8 : rotate-by-ptr priority pick of the first request from ptr    |
// | Rev 1.0 : initial release                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_pick8
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] pick,
  output logic            any
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  logic [ID_W-1:0]   w_off;

  // Doubling the vector turns the right shift into a rotate; bit 0 is then req[ptr].
  assign w_dbl = {req, req} >> ptr;
  assign w_rot = w_dbl[NREQ-1:0];

  always_comb begin
    w_off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = i[ID_W-1:0];
    end
  end

  assign pick = ptr + w_off;
  assign any  = |req;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter8.sv
// +--------------------------------------------------------------------------+
// | rr_arbiter8 : 8-way round-robin arbiter, owner holds until it releases. |
// | Optional forced release after MAX_HOLD cycles: define ARB_TIMEOUT_EN.   |
// | Rev 1.0 : initial release                                               |
// +--------------------------------------------------------------------------+
`default_nettype none

module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic            grant_vld,
  output logic [ID_W-1:0] grant_id,
  output logic            timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter8: MAX_HOLD must be in 2..255");
  end

  state_t          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            timeout_q, timeout_d;
  logic [ID_W-1:0] w_pick;
  logic            w_any;

  rr_pick8 u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (w_pick),
    .any  (w_any)
  );

`ifdef ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] c_HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    id_d      = id_q;
    timeout_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (w_any) begin
          grant_d = id2onehot(w_pick);
          id_d    = w_pick;
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[id_q]) begin
          grant_d = '0;
          ptr_d   = id_q + 1'b1;
          state_d = IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        // Owner still requesting at the limit: release exactly as if it had dropped.
        else if (hold_cnt_q == c_HOLD_LAST) begin
          grant_d   = '0;
          ptr_d     = id_q + 1'b1;
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      id_q      <= '0;
      timeout_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      timeout_q <= timeout_d;
`ifdef ARB_TIMEOUT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign grant     = grant_q;
  assign grant_vld = (state_q == GRANT);
  assign grant_id  = id_q;
  assign timeout   = timeout_q;

endmodule

`default_nettype wire
